fft_frame_loader: RTL and testbench

//  Byte-serial front end for the 8-point radix-2 FFT/IFFT core. Accepts a stream of bytes

---
 rtl/fft_frame_loader.sv | 179 +++++++++++++++++
 tb/tb_fft_frame_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_loader.sv
// Byte-serial frame loader for the 8-point FFT/IFFT core: assembles 32 bytes into held
// parallel sample outputs and times the core latency. Optional FRAME_CHECKSUM_EN adds an XOR check byte.
module fft_frame_loader #(
    parameter int NPTS        = 8,
    parameter int DATA_W      = 16,
    parameter int FFT_LATENCY = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     mode_in,
    output logic [NPTS*DATA_W-1:0]   xr_flat,
    output logic [NPTS*DATA_W-1:0]   xi_flat,
    output logic                     mode_out,
    output logic                     frame_valid,
    output logic                     result_valid,
    output logic                     frame_err
);

    localparam int FRAME_BYTES = (NPTS * DATA_W * 2) / 8;
    localparam int BUF_W       = FRAME_BYTES * 8;
    localparam int CNT_W       = $clog2(FRAME_BYTES);
    localparam int LAT_W       = $clog2(FFT_LATENCY + 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
    localparam logic [LAT_W-1:0] LAST_LAT  = LAT_W'(FFT_LATENCY - 1);

    typedef enum logic {
        S_LOAD,
        S_WAIT
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         byte_cnt_q, byte_cnt_d;
    logic [BUF_W-1:0]         staging_q, staging_d;
    logic [NPTS*DATA_W-1:0]   xr_q, xr_d;
    logic [NPTS*DATA_W-1:0]   xi_q, xi_d;
    logic                     mode_q, mode_d;
    logic                     frame_valid_q, frame_valid_d;
    logic [LAT_W-1:0]         lat_cnt_q, lat_cnt_d;

    logic                     accept;
    logic                     commit;
    logic [BUF_W-1:0]         commit_buf;

`ifdef FRAME_CHECKSUM_EN
    logic [7:0]               csum_q, csum_d;
    logic                     chk_phase_q, chk_phase_d;
    logic                     frame_err_q, frame_err_d;
`endif

    assign accept = in_valid && (state_q == S_LOAD);

    always_comb begin
        // NOTE: every signal gets a default before any branch; a path that skipped one would infer a latch.
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        staging_d     = staging_q;
        xr_d          = xr_q;
        xi_d          = xi_q;
        mode_d        = mode_q;
        frame_valid_d = frame_valid_q;
        lat_cnt_d     = lat_cnt_q;
        commit        = 1'b0;
        commit_buf    = staging_q;
`ifdef FRAME_CHECKSUM_EN
        csum_d        = csum_q;
        chk_phase_d   = chk_phase_q;
        frame_err_d   = frame_err_q;
`endif

        unique case (state_q)
            S_LOAD: begin
                if (accept) begin
`ifdef FRAME_CHECKSUM_EN
                    if (chk_phase_q) begin
                        // Check byte: staging already holds all 32 data bytes.
                        chk_phase_d = 1'b0;
                        csum_d      = 8'h00;
                        byte_cnt_d  = '0;
                        if (in_data == csum_q) begin
                            commit = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        staging_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
                        csum_d     = csum_q ^ in_data;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        if (byte_cnt_q == LAST_BYTE) begin
                            chk_phase_d = 1'b1;
                        end
                    end
                    commit_buf = staging_q;
`else
                    staging_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    commit     = (byte_cnt_q == LAST_BYTE);
                    // The final byte must reach the outputs in the same edge it is accepted.
                    commit_buf = staging_d;
`endif
                    if (commit) begin
                        for (int k = 0; k < NPTS; k++) begin
                            xr_d[DATA_W*k +: DATA_W] = commit_buf[2*DATA_W*k +: DATA_W];
                            xi_d[DATA_W*k +: DATA_W] = commit_buf[2*DATA_W*k + DATA_W +: DATA_W];
                        end
                        mode_d        = mode_in;
                        frame_valid_d = 1'b1;
                        lat_cnt_d     = '0;
                        state_d       = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (lat_cnt_q == LAST_LAT) begin
                    frame_valid_d = 1'b0;
                    lat_cnt_d     = '0;
                    state_d       = S_LOAD;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end

            default: state_d = S_LOAD;
        endcase
    end

    // NOTE: the staging buffer is a plain register array, not a RAM, so it can be cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_LOAD;
            byte_cnt_q    <= '0;
            staging_q     <= '0;
            xr_q          <= '0;
            xi_q          <= '0;
            mode_q        <= 1'b0;
            frame_valid_q <= 1'b0;
            lat_cnt_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            staging_q     <= staging_d;
            xr_q          <= xr_d;
            xi_q          <= xi_d;
            mode_q        <= mode_d;
            frame_valid_q <= frame_valid_d;
            lat_cnt_q     <= lat_cnt_d;
        end
    end

`ifdef FRAME_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q      <= 8'h00;
            chk_phase_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            csum_q      <= csum_d;
            chk_phase_q <= chk_phase_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

    assign in_ready     = (state_q == S_LOAD);
    assign result_valid = (state_q == S_WAIT) && (lat_cnt_q == LAST_LAT);
    assign xr_flat      = xr_q;
    assign xi_flat      = xi_q;
    assign mode_out     = mode_q;
    assign frame_valid  = frame_valid_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Self-checking bench for fft_frame_loader: table of frames, scoreboard of committed
// frames popped on result_valid, plus hand-written timing, backpressure and reset sequences.
module tb_fft_frame_loader;

    localparam int LAT = 4;
`ifdef FRAME_CHECKSUM_EN
    localparam int NB = 33;
`else
    localparam int NB = 32;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   in_data = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         mode_in = 1'b0;
    logic [127:0] xr_flat;
    logic [127:0] xi_flat;
    logic         mode_out;
    logic         frame_valid;
    logic         result_valid;
    logic         frame_err;

    fft_frame_loader #(.NPTS(8), .DATA_W(16), .FFT_LATENCY(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mode_in      (mode_in),
        .xr_flat      (xr_flat),
        .xi_flat      (xi_flat),
        .mode_out     (mode_out),
        .frame_valid  (frame_valid),
        .result_valid (result_valid),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0][15:0] re;
        logic [7:0][15:0] im;
        logic             mode;
        bit               gappy;
    } vec_t;

    typedef struct {
        logic [127:0] xr;
        logic [127:0] xi;
        logic         mode;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_commit;
    vec_t vecs[6];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic exp_t pack(input vec_t v);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            e.xr[16*k +: 16] = v.re[k];
            e.xi[16*k +: 16] = v.im[k];
        end
        e.mode = v.mode;
        return e;
    endfunction

    function automatic logic [7:0] get_byte(input vec_t v, input int i);
        logic [15:0] w;
        w = ((i % 4) < 2) ? v.re[i/4] : v.im[i/4];
        return ((i % 2) == 0) ? w[7:0] : w[15:8];
    endfunction

    // Scoreboard: every result_valid pulse must match the oldest committed frame.
    always @(negedge clk) begin
        if (!reset && result_valid) begin
            check("result_expected", {127'b0, sb_q.size() != 0}, 128'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_xr", xr_flat, e.xr);
                check("sb_xi", xi_flat, e.xi);
                check("sb_mode", {127'b0, mode_out}, {127'b0, e.mode});
                check("sb_frame_valid", {127'b0, frame_valid}, 128'd1);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic m, input bit gappy);
        int n;
        if (gappy) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        mode_in  = m;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", {127'b0, in_ready}, 128'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input vec_t v, input int start, input bit corrupt, input int nbytes);
        logic [7:0] cs;
        logic [7:0] b;
        bit         last;
        exp_t       e;
        cs = 8'h00;
        for (int i = 0; i < 32; i++) cs ^= get_byte(v, i);
        for (int i = start; i < nbytes; i++) begin
            last = (i == NB - 1);
            b = (i < 32) ? get_byte(v, i) : (cs ^ {7'b0, corrupt});
            if (last) begin
                check("hold_xr", xr_flat, last_commit.xr);
                check("hold_xi", xi_flat, last_commit.xi);
                if (!corrupt) begin
                    e = pack(v);
                    sb_q.push_back(e);
                    last_commit = e;
                end
            end
            // mode_in differs from the frame mode on every byte except the committing one.
            send_byte(b, last ? v.mode : ~v.mode, v.gappy);
        end
    endtask

    // Entered at the negedge right after the commit edge (k=0 is cycle N+1).
    task automatic check_wait_window();
        for (int k = 0; k <= LAT; k++) begin
            check($sformatf("win_ready_%0d", k), {127'b0, in_ready}, {127'b0, k == LAT});
            check($sformatf("win_fv_%0d", k), {127'b0, frame_valid}, {127'b0, k < LAT});
            check($sformatf("win_rv_%0d", k), {127'b0, result_valid}, {127'b0, k == LAT - 1});
            if (k < LAT) @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_xr"}, xr_flat, 128'd0);
        check({tag, "_xi"}, xi_flat, 128'd0);
        check({tag, "_mode"}, {127'b0, mode_out}, 128'd0);
        check({tag, "_fv"}, {127'b0, frame_valid}, 128'd0);
        check({tag, "_rv"}, {127'b0, result_valid}, 128'd0);
        check({tag, "_err"}, {127'b0, frame_err}, 128'd0);
    endtask

    task automatic do_reset(input string tag);
        in_valid = 1'b0;
        reset    = 1'b1;
        sb_q.delete();
        repeat (2) @(negedge clk);
        check_reset_outputs(tag);
        reset = 1'b0;
        @(negedge clk);
        check({tag, "_ready"}, {127'b0, in_ready}, 128'd1);
        last_commit = '{xr: '0, xi: '0, mode: 1'b0};
    endtask

    initial begin
        int start;
        last_commit = '{xr: '0, xi: '0, mode: 1'b0};

        for (int k = 0; k < 8; k++) begin
            vecs[0].re[k] = (k == 0) ? 16'h1000 : 16'h0000;
            vecs[0].im[k] = 16'h0000;
            vecs[1].re[k] = 16'(16'h0100 * k);
            vecs[1].im[k] = 16'(-(16'h0100 * k));
            vecs[2].re[k] = 16'($urandom);
            vecs[2].im[k] = 16'($urandom);
            vecs[4].re[k] = k[0] ? 16'h8000 : 16'h7FFF;
            vecs[4].im[k] = k[0] ? 16'h0001 : 16'hFFFF;
            vecs[5].re[k] = 16'($urandom);
            vecs[5].im[k] = 16'($urandom);
        end
        vecs[0].mode = 1'b0; vecs[0].gappy = 1'b0;
        vecs[1].mode = 1'b1; vecs[1].gappy = 1'b0;
        vecs[2].mode = 1'b0; vecs[2].gappy = 1'b0;
        vecs[3] = vecs[2];   vecs[3].gappy = 1'b1;
        vecs[4].mode = 1'b1; vecs[4].gappy = 1'b1;
        vecs[5].mode = 1'b1; vecs[5].gappy = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check("reset_ready", {127'b0, in_ready}, 128'd1);

        start = 0;
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i], start, 1'b0, NB);
            start = 0;
            if (i == 1) begin
                // Backpressure: next frame's byte 0 held valid through the whole wait.
                in_valid = 1'b1;
                in_data  = get_byte(vecs[2], 0);
                mode_in  = ~vecs[2].mode;
                check_wait_window();
                @(negedge clk);
                in_valid = 1'b0;
                start = 1;
            end else begin
                check_wait_window();
            end
            if (i == 0) begin
                check("impulse_re0", {112'b0, xr_flat[15:0]}, 128'h1000);
                check("impulse_rest", {xr_flat[127:16], 16'h0000} | xi_flat, 128'd0);
            end
            if (i == 1) begin
                check("ramp_re1", {112'b0, xr_flat[31:16]}, 128'h0100);
                check("ramp_im7", {112'b0, xi_flat[127:112]}, 128'hF900);
                check("ramp_mode", {127'b0, mode_out}, 128'd1);
            end
        end

        // Reset after 17 bytes, then a complete frame must load cleanly.
        send_frame(vecs[5], 0, 1'b0, 17);
        do_reset("rst_mid");
        send_frame(vecs[2], 0, 1'b0, NB);
        check_wait_window();

        // Reset while waiting discards the pending result_valid.
        send_frame(vecs[4], 0, 1'b0, NB);
        @(negedge clk);
        do_reset("rst_wait");
        repeat (LAT + 2) @(negedge clk);
        send_frame(vecs[1], 0, 1'b0, NB);
        check_wait_window();

`ifdef FRAME_CHECKSUM_EN
        send_frame(vecs[5], 0, 1'b1, NB);
        repeat (LAT + 2) @(negedge clk);
        check("csum_err", {127'b0, frame_err}, 128'd1);
        check("csum_no_fv", {127'b0, frame_valid}, 128'd0);
        check("csum_xr_kept", xr_flat, last_commit.xr);
        check("csum_ready", {127'b0, in_ready}, 128'd1);
        send_frame(vecs[5], 0, 1'b0, NB);
        check_wait_window();
        check("csum_err_sticky", {127'b0, frame_err}, 128'd1);
`else
        check("err_tied", {127'b0, frame_err}, 128'd0);
`endif

        repeat (LAT + 2) @(negedge clk);
        check("sb_drained", {96'b0, 32'(sb_q.size())}, 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
